// File: rtl/branch_precheck_d.sv
// Dual-lane LA32R branch precheck between the instruction buffer and the decoder.
// Optional PRECHECK_STATS_EN adds saturating redirect/drop counters.
//
// state   | meaning
// S_RUN   | normal flow, beats checked and forwarded
// S_DRAIN | after a redirect, discard beats until the redirect target or timeout
module branch_precheck_d #(
   parameter bit          CHECK_COND_TGT = 1'b1,
   parameter int unsigned DRAIN_TIMEOUT  = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [1:0]       in_valid,
   input  logic [1:0][31:0] in_pc,
   input  logic [1:0][31:0] in_inst,
   input  logic [1:0]       in_is_exception,
   input  logic [1:0]       in_pre_taken,
   input  logic [31:0]      in_pre_addr,
   output logic             in_ready,
   output logic [1:0]       out_valid,
   output logic [1:0][31:0] out_pc,
   output logic [1:0][31:0] out_inst,
   output logic [1:0]       out_is_exception,
   output logic [1:0]       out_pre_taken,
   output logic [31:0]      out_pre_addr,
   input  logic             out_ready,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc
`ifdef PRECHECK_STATS_EN
  ,output logic [31:0]      stat_redirect_cnt,
   output logic [31:0]      stat_drop_cnt
`endif
);

   localparam logic [5:0] OP_JIRL = 6'b010011;
   localparam logic [5:0] OP_B    = 6'b010100;
   localparam logic [5:0] OP_BL   = 6'b010101;
   localparam logic [5:0] OP_BEQ  = 6'b010110;
   localparam logic [5:0] OP_BGEU = 6'b011011;
   localparam logic [3:0] TIMEOUT_C = 4'(DRAIN_TIMEOUT);

   typedef enum logic {S_RUN, S_DRAIN} state_e;

   typedef struct packed {
      logic [1:0]       valid;
      logic [1:0][31:0] pc;
      logic [1:0][31:0] inst;
      logic [1:0]       exc;
      logic [1:0]       taken;
      logic [31:0]      addr;
   } beat_t;

   typedef struct packed {
      logic        need;
      logic [31:0] rpc;
      logic        taken;
      logic [31:0] addr;
   } chk_t;

   function automatic chk_t check_lane(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic pre_taken, input logic [31:0] pre_addr);
      logic [5:0]  opc;
      logic        is_b;
      logic        is_cond;
      logic        is_jirl;
      logic [31:0] tgt;
      chk_t        r;
      opc     = inst[31:26];
      is_b    = (opc == OP_B) || (opc == OP_BL);
      is_cond = (opc >= OP_BEQ) && (opc <= OP_BGEU);
      is_jirl = (opc == OP_JIRL);
      tgt     = is_b ? pc + {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00}
                     : pc + {{14{inst[25]}}, inst[25:10], 2'b00};
      r.need  = 1'b0;
      r.rpc   = pc + 32'd4;
      r.taken = pre_taken;
      r.addr  = pre_addr;
      if (pre_taken && !(is_b || is_cond || is_jirl)) begin
         r.need  = 1'b1;
         r.taken = 1'b0;
      end else if (is_b && (!pre_taken || (pre_addr != tgt))) begin
         r.need  = 1'b1;
         r.rpc   = tgt;
         r.taken = 1'b1;
         r.addr  = tgt;
      end else if (CHECK_COND_TGT && is_cond && pre_taken && (pre_addr != tgt)) begin
         r.need  = 1'b1;
         r.rpc   = tgt;
         r.addr  = tgt;
      end
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   beat_t       out_q, out_d, skid_q, skid_d, new_beat;
   logic        skid_full_q, skid_full_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_pc_q, rd_pc_d;
   chk_t        chk0, chk1;
   logic        rd_need;
   logic [31:0] rd_tgt;
   logic        beat_in, drain_hit, take_beat, out_free;

   assign in_ready  = !skid_full_q;
   assign beat_in   = (in_valid != 2'b00) && in_ready;
   assign drain_hit = in_valid[0] && (in_pc[0] == rd_pc_q);
   assign out_free  = (out_q.valid == 2'b00) || out_ready;

   // Lane 0 wins; a taken or redirecting lane 0 makes lane 1 wrong-path.
   always_comb begin
      chk0           = check_lane(in_pc[0], in_inst[0], in_pre_taken[0], in_pre_addr);
      chk1           = check_lane(in_pc[1], in_inst[1], in_pre_taken[1], in_pre_addr);
      new_beat.valid = in_valid;
      new_beat.pc    = in_pc;
      new_beat.inst  = in_inst;
      new_beat.exc   = in_is_exception;
      new_beat.taken = in_pre_taken;
      new_beat.addr  = in_pre_addr;
      rd_need        = 1'b0;
      rd_tgt         = '0;
      if (in_valid[0] && !in_is_exception[0]) begin
         new_beat.taken[0] = chk0.taken;
         new_beat.addr     = chk0.addr;
         if (chk0.need) begin
            rd_need = 1'b1;
            rd_tgt  = chk0.rpc;
         end
      end
      if (in_valid[0] && (rd_need || new_beat.taken[0])) begin
         new_beat.valid[1] = 1'b0;
         new_beat.taken[1] = 1'b0;
      end else if (in_valid[1] && !in_is_exception[1]) begin
         new_beat.taken[1] = chk1.taken;
         new_beat.addr     = chk1.addr;
         if (chk1.need) begin
            rd_need = 1'b1;
            rd_tgt  = chk1.rpc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (take_beat && rd_need) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (take_beat) begin
               state_d = rd_need ? S_DRAIN : S_RUN;
               cnt_d   = '0;
            end else if ((cnt_q + 4'd1) == TIMEOUT_C) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      take_beat = 1'b0;
      if (beat_in && ((state_q == S_RUN) || drain_hit)) take_beat = 1'b1;
   end

   // Skid content is always older than anything upstream, so it drains first.
   always_comb begin
      out_d       = out_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      rd_valid_d  = 1'b0;
      rd_pc_d     = rd_pc_q;
      if (out_free) begin
         if (skid_full_q) begin
            out_d       = skid_q;
            skid_full_d = 1'b0;
         end else if (take_beat) begin
            out_d = new_beat;
         end else begin
            out_d.valid = 2'b00;
         end
      end else if (take_beat) begin
         skid_d      = new_beat;
         skid_full_d = 1'b1;
      end
      if (take_beat && rd_need) begin
         rd_valid_d = 1'b1;
         rd_pc_d    = rd_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_q       <= '0;
         skid_q      <= '0;
         skid_full_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_pc_q     <= '0;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
         rd_valid_q  <= rd_valid_d;
         rd_pc_q     <= rd_pc_d;
      end
   end

   assign out_valid        = out_q.valid;
   assign out_pc           = out_q.pc;
   assign out_inst         = out_q.inst;
   assign out_is_exception = out_q.exc;
   assign out_pre_taken    = out_q.taken;
   assign out_pre_addr     = out_q.addr;
   assign redirect_valid   = rd_valid_q;
   assign redirect_pc      = rd_pc_q;

`ifdef PRECHECK_STATS_EN
   logic [31:0] stat_rd_q, stat_rd_d, stat_drop_q, stat_drop_d;

   // Statistics survive flush; only rst clears them.
   always_comb begin
      stat_rd_d   = stat_rd_q;
      stat_drop_d = stat_drop_q;
      if (rd_valid_q && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + 32'd1;
      if (beat_in && !take_beat && !flush && (stat_drop_q != '1)) stat_drop_d = stat_drop_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q   <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_rd_q   <= stat_rd_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_redirect_cnt = stat_rd_q;
   assign stat_drop_cnt     = stat_drop_q;
`endif

endmodule

// File: tb/tb_branch_precheck_d.sv
// Directed scoreboard bench for branch_precheck_d (main instance plus a CHECK_COND_TGT=0 instance).
module tb_branch_precheck_d;

   localparam logic [31:0] B40   = 32'h5000_4000;
   localparam logic [31:0] BL40  = 32'h5400_4000;
   localparam logic [31:0] BEQM4 = 32'h5BFF_FC00;
   localparam logic [31:0] ADDW  = 32'h0010_0000;

   logic             clk = 1'b0;
   logic             rst, flush;
   logic [1:0]       in_valid, in_is_exception, in_pre_taken;
   logic [1:0][31:0] in_pc, in_inst;
   logic [31:0]      in_pre_addr;
   logic             in_ready, out_ready;
   logic [1:0]       out_valid, out_is_exception, out_pre_taken;
   logic [1:0][31:0] out_pc, out_inst;
   logic [31:0]      out_pre_addr;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;

   logic             nc_in_ready;
   logic [1:0]       nc_out_valid, nc_out_is_exception, nc_out_pre_taken;
   logic [1:0][31:0] nc_out_pc, nc_out_inst;
   logic [31:0]      nc_out_pre_addr;
   logic             nc_redirect_valid;
   logic [31:0]      nc_redirect_pc;
`ifdef PRECHECK_STATS_EN
   logic [31:0]      stat_redirect_cnt, stat_drop_cnt, nc_stat_redirect_cnt, nc_stat_drop_cnt;
`endif

   typedef struct packed {
      logic [1:0]  v;
      logic [31:0] pc0;
      logic [1:0]  t;
      logic [31:0] a;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rdq[$];
   exp_t        mon_e;
   logic [31:0] mon_r;
   int          n_pass = 0;
   int          n_tot  = 0;

   always #5 clk = ~clk;

   branch_precheck_d #(.CHECK_COND_TGT(1'b1), .DRAIN_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_is_exception(in_is_exception), .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_is_exception(out_is_exception), .out_pre_taken(out_pre_taken), .out_pre_addr(out_pre_addr),
      .out_ready(out_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef PRECHECK_STATS_EN
     ,.stat_redirect_cnt(stat_redirect_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
   );

   branch_precheck_d #(.CHECK_COND_TGT(1'b0), .DRAIN_TIMEOUT(15)) dut_nc (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_is_exception(in_is_exception), .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr),
      .in_ready(nc_in_ready),
      .out_valid(nc_out_valid), .out_pc(nc_out_pc), .out_inst(nc_out_inst),
      .out_is_exception(nc_out_is_exception), .out_pre_taken(nc_out_pre_taken),
      .out_pre_addr(nc_out_pre_addr),
      .out_ready(out_ready),
      .redirect_valid(nc_redirect_valid), .redirect_pc(nc_redirect_pc)
`ifdef PRECHECK_STATS_EN
     ,.stat_redirect_cnt(nc_stat_redirect_cnt), .stat_drop_cnt(nc_stat_drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] v, input logic [31:0] pc0, input logic [1:0] t,
                           input logic [31:0] a);
      exp_t e;
      e.v = v; e.pc0 = pc0; e.t = t; e.a = a;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] exc, input logic [31:0] pc0,
                        input logic [31:0] i0, input logic [31:0] pc1, input logic [31:0] i1,
                        input logic [1:0] pt, input logic [31:0] pa);
      in_valid        = v;
      in_is_exception = exc;
      in_pc[0]        = pc0;
      in_inst[0]      = i0;
      in_pc[1]        = pc1;
      in_inst[1]      = i1;
      in_pre_taken    = pt;
      in_pre_addr     = pa;
   endtask

   // Holds the driven beat until the stage takes it, bounded.
   task automatic wait_accept(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 96'(in_ready), 96'(1));
      tick();
      in_valid = 2'b00;
   endtask

   task automatic send(input string tag, input logic [1:0] v, input logic [1:0] exc,
                       input logic [31:0] pc0, input logic [31:0] i0, input logic [31:0] pc1,
                       input logic [31:0] i1, input logic [1:0] pt, input logic [31:0] pa);
      drive(v, exc, pc0, i0, pc1, i1, pt, pa);
      wait_accept(tag);
   endtask

   always @(negedge clk) begin
      if (!rst && !flush && out_ready && (out_valid != 2'b00)) begin
         n_tot++;
         assert (exp_q.size() != 0) n_pass++;
         else $error("FAIL beat_unexpected observed pc=%0h expected none", out_pc[0]);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("beat", 96'({out_valid, out_pc[0], out_pre_taken, out_pre_addr}), 96'(mon_e));
         end
      end
      if (!rst && redirect_valid) begin
         n_tot++;
         assert (rdq.size() != 0) n_pass++;
         else $error("FAIL redirect_unexpected observed pc=%0h expected none", redirect_pc);
         if (rdq.size() != 0) begin
            mon_r = rdq.pop_front();
            chk("redirect_pc", 96'(redirect_pc), 96'(mon_r));
         end
      end
   end

   initial begin
      int i;
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_redirect_valid", 96'(redirect_valid), 96'(0));
      chk("rst_redirect_pc", 96'(redirect_pc), 96'(0));
      chk("rst_pre_taken", 96'(out_pre_taken), 96'(0));
      chk("rst_pre_addr", 96'(out_pre_addr), 96'(0));
      chk("rst_in_ready", 96'(in_ready), 96'(1));
      tick();

      // B predicted not taken
      push_exp(2'b01, 32'h1c00_0000, 2'b01, 32'h1c00_0040);
      rdq.push_back(32'h1c00_0040);
      send("acc_b", 2'b11, 2'b00, 32'h1c00_0000, B40, 32'h1c00_0004, ADDW, 2'b00, 32'h0);
      @(negedge clk);
      chk("b_redirect_valid", 96'(redirect_valid), 96'(1));
      chk("b_redirect_pc", 96'(redirect_pc), 96'(32'h1c00_0040));
      chk("b_lane1_killed", 96'(out_valid), 96'(2'b01));
      chk("b_pre_taken0", 96'(out_pre_taken[0]), 96'(1));
      chk("drain_in_ready", 96'(in_ready), 96'(1));
      tick();
      send("drop_a", 2'b11, 2'b00, 32'h1c00_0008, ADDW, 32'h1c00_000c, ADDW, 2'b00, 32'h0);
      send("drop_b", 2'b11, 2'b00, 32'h1c00_0010, ADDW, 32'h1c00_0014, ADDW, 2'b00, 32'h0);
      push_exp(2'b11, 32'h1c00_0040, 2'b00, 32'h0);
      send("drain_hit", 2'b11, 2'b00, 32'h1c00_0040, ADDW, 32'h1c00_0044, ADDW, 2'b00, 32'h0);
      @(negedge clk);
      chk("drain_hit_out", 96'({out_valid, out_pc[0]}), 96'({2'b11, 32'h1c00_0040}));
      tick();

      // lane 1 non-branch predicted taken
      push_exp(2'b11, 32'h1c00_0100, 2'b00, 32'h1c00_0500);
      rdq.push_back(32'h1c00_0108);
      send("acc_l1", 2'b11, 2'b00, 32'h1c00_0100, ADDW, 32'h1c00_0104, ADDW, 2'b10, 32'h1c00_0500);
      @(negedge clk);
      chk("l1_pre_taken", 96'(out_pre_taken), 96'(2'b00));
      chk("l1_valid", 96'(out_valid), 96'(2'b11));
      tick();
      push_exp(2'b01, 32'h1c00_0108, 2'b00, 32'h0);
      send("l1_target", 2'b01, 2'b00, 32'h1c00_0108, ADDW, 32'h0, 32'h0, 2'b00, 32'h0);

      // BEQ taken with wrong target, then drain timeout
      push_exp(2'b01, 32'h1c00_0200, 2'b01, 32'h1c00_01fc);
      rdq.push_back(32'h1c00_01fc);
      send("acc_beq", 2'b01, 2'b00, 32'h1c00_0200, BEQM4, 32'h1c00_0204, ADDW, 2'b01, 32'h1c00_0300);
      @(negedge clk);
      chk("beq_redirect", 96'(redirect_valid), 96'(1));
      chk("beq_nc_no_redirect", 96'(nc_redirect_valid), 96'(0));
      chk("beq_nc_pre_addr", 96'(nc_out_pre_addr), 96'(32'h1c00_0300));
      push_exp(2'b01, 32'h1c00_0800, 2'b00, 32'h0);
      drive(2'b01, 2'b00, 32'h1c00_0800, ADDW, 32'h1c00_0804, ADDW, 2'b00, 32'h0);
      i = 0;
      while (i < 30) begin
         tick();
         i++;
         if (i == 8) chk("timeout_in_ready", 96'(in_ready), 96'(1));
         if (out_valid[0] && (out_pc[0] == 32'h1c00_0800)) break;
      end
      in_valid = 2'b00;
      chk("drain_timeout", 96'(i), 96'(16));

      // B taken with correct target
      push_exp(2'b01, 32'h1c00_0c00, 2'b01, 32'h1c00_0c40);
      send("acc_bok", 2'b11, 2'b00, 32'h1c00_0c00, B40, 32'h1c00_0c04, ADDW, 2'b01, 32'h1c00_0c40);
      @(negedge clk);
      chk("bok_no_redirect", 96'(redirect_valid), 96'(0));
      tick();

      // BL taken with wrong target
      push_exp(2'b01, 32'h1c00_0d00, 2'b01, 32'h1c00_0d40);
      rdq.push_back(32'h1c00_0d40);
      send("acc_bl", 2'b11, 2'b00, 32'h1c00_0d00, BL40, 32'h1c00_0d04, ADDW, 2'b01, 32'h1c00_0000);
      @(negedge clk);
      chk("bl_fixed_addr", 96'(out_pre_addr), 96'(32'h1c00_0d40));
      tick();
      push_exp(2'b01, 32'h1c00_0d40, 2'b00, 32'h0);
      send("bl_target", 2'b01, 2'b00, 32'h1c00_0d40, ADDW, 32'h0, 32'h0, 2'b00, 32'h0);

      // lane 0 exception skips the check
      push_exp(2'b11, 32'h1c00_0b00, 2'b00, 32'h1c00_0777);
      send("acc_exc", 2'b11, 2'b01, 32'h1c00_0b00, B40, 32'h1c00_0b04, ADDW, 2'b00, 32'h1c00_0777);
      @(negedge clk);
      chk("exc_no_redirect", 96'(redirect_valid), 96'(0));
      chk("exc_passthrough", 96'(out_is_exception), 96'(2'b01));
      tick();

      // stall: second beat parks in the skid, third is held upstream
      out_ready = 1'b0;
      push_exp(2'b11, 32'h1c00_0900, 2'b00, 32'h0);
      push_exp(2'b11, 32'h1c00_0910, 2'b00, 32'h0);
      push_exp(2'b11, 32'h1c00_0920, 2'b00, 32'h0);
      send("skid_a", 2'b11, 2'b00, 32'h1c00_0900, ADDW, 32'h1c00_0904, ADDW, 2'b00, 32'h0);
      send("skid_b", 2'b11, 2'b00, 32'h1c00_0910, ADDW, 32'h1c00_0914, ADDW, 2'b00, 32'h0);
      drive(2'b11, 2'b00, 32'h1c00_0920, ADDW, 32'h1c00_0924, ADDW, 2'b00, 32'h0);
      @(negedge clk);
      chk("skid_in_ready", 96'(in_ready), 96'(0));
      chk("skid_out_held", 96'(out_pc[0]), 96'(32'h1c00_0900));
      tick();
      out_ready = 1'b1;
      wait_accept("skid_c");
      tick();

      // flush with a full skid and an upstream beat waiting
      out_ready = 1'b0;
      send("fl_d", 2'b11, 2'b00, 32'h1c00_0e00, ADDW, 32'h1c00_0e04, ADDW, 2'b00, 32'h0);
      send("fl_e", 2'b11, 2'b00, 32'h1c00_0e10, ADDW, 32'h1c00_0e14, ADDW, 2'b00, 32'h0);
      drive(2'b11, 2'b00, 32'h1c00_0e20, B40, 32'h1c00_0e24, ADDW, 2'b00, 32'h0);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      in_valid  = 2'b00;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", 96'(out_valid), 96'(0));
      chk("flush_redirect", 96'(redirect_valid), 96'(0));
      chk("flush_in_ready", 96'(in_ready), 96'(1));
      chk("flush_redirect_pc", 96'(redirect_pc), 96'(0));
      tick();

      // flush and a redirecting beat in the same cycle
      drive(2'b11, 2'b00, 32'h1c00_0f00, B40, 32'h1c00_0f04, ADDW, 2'b00, 32'h0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 2'b00;
      @(negedge clk);
      chk("flush_beat_redirect", 96'(redirect_valid), 96'(0));
      chk("flush_beat_out", 96'(out_valid), 96'(0));
      tick();
      push_exp(2'b01, 32'h1c00_0a00, 2'b00, 32'h0);
      send("post_flush", 2'b01, 2'b00, 32'h1c00_0a00, ADDW, 32'h0, 32'h0, 2'b00, 32'h0);
      @(negedge clk);
      chk("post_flush_run", 96'(out_valid), 96'(2'b01));
      tick();

      repeat (3) tick();
      chk("sb_empty", 96'(exp_q.size()), 96'(0));
      chk("rd_empty", 96'(rdq.size()), 96'(0));
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
